// File: rtl/montgomery_mul_param.sv
// montgomery_mul_param: bit-serial radix-2 Montgomery multiplier, result = A*B*2^(-WIDTH) mod M.
// One bit of A is consumed per clock, LSB first; one multiplication in flight at a time.
// Build option MONT_FINAL_SUB_EN: adds a final conditional subtraction so the result is fully
// reduced (0 <= result < M). Without it the result is lazily reduced (congruent, and < 2M).
module montgomery_mul_param #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int ACC_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef MONT_FINAL_SUB_EN
  typedef enum logic [1:0] {IDLE, LOOP, SUB, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOOP, DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] mReg;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] sumAB;
  logic [ACC_W-1:0] sumM;
  logic [ACC_W-1:0] accNext;

  // One Montgomery step: add a_i*B, make the sum even by adding M if needed, then halve.
  // Two guard bits keep acc + B + M (< 4M) from overflowing while acc stays below 2M.
  always_comb begin
    sumAB   = acc + (aReg[0] ? {2'b00, bReg} : '0);
    sumM    = sumAB[0] ? (sumAB + {2'b00, mReg}) : sumAB;
    accNext = sumM >> 1;
  end

`ifdef MONT_FINAL_SUB_EN
  logic [ACC_W-1:0] diff;
  logic [WIDTH-1:0] reduced;

  // Final reduction: acc < 2M, so one trial subtraction of M brings it into [0, M).
  always_comb begin
    diff    = acc - {2'b00, mReg};
    reduced = diff[ACC_W-1] ? acc[WIDTH-1:0] : diff[WIDTH-1:0];
  end
`endif

  // Control FSM and datapath registers; busy and done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      aReg   <= '0;
      bReg   <= '0;
      mReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            aReg  <= in_a;
            bReg  <= in_b;
            mReg  <= in_m;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOOP;
          end
        end
        LOOP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc  <= accNext;
            aReg <= aReg >> 1;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) begin
`ifdef MONT_FINAL_SUB_EN
              state <= SUB;
`else
              result <= accNext[WIDTH-1:0];
              done   <= 1'b1;
              state  <= DONE;
`endif
            end
          end
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc    <= {2'b00, reduced};
            result <= reduced;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mul_param.sv
// tb_montgomery_mul_param: directed self-checking bench for montgomery_mul_param at WIDTH=8, M=13.
// Expected products were worked by hand (R = 256, R^-1 mod 13 = 3). Honours MONT_FINAL_SUB_EN for latency.
module tb_montgomery_mul_param;

  localparam int W = 8;
`ifdef MONT_FINAL_SUB_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic [W-1:0] inM;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checkCount = 0;
  int failCount  = 0;

  montgomery_mul_param #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .in_a   (inA),
    .in_b   (inB),
    .in_m   (inM),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present operands with a one-cycle start pulse; returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    inA   = a;
    inB   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run one multiplication and check latency, busy, result and the single-cycle done pulse.
  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int unsigned expRes);
    int n;
    bit busyOk;
    n = 0;
    busyOk = 1'b1;
    applyStimulus(a, b);
    while (!done && n < LAT + 20) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b1) busyOk = 1'b0;
    checkOutput({tag, " latency"}, n, LAT);
    checkOutput({tag, " busy"}, busyOk, 1);
    checkOutput({tag, " result"}, result, expRes);
    @(posedge clk);
    #1;
    checkOutput({tag, " done pulse"}, done, 0);
    checkOutput({tag, " idle"}, busy, 0);
    checkOutput({tag, " result hold"}, result, expRes);
  endtask

  initial begin
    int doneCount;
    int n;
    bit resOk;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    inA   = '0;
    inB   = '0;
    inM   = 8'd13;

    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    // Abort four cycles into an operation: back to idle, no done, result untouched.
    applyStimulus(8'd5, 8'd7);
    checkOutput("abort busy before", busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort result", result, 0);
    doneCount = 0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);
    checkOutput("abort result kept", result, 0);

    // Directed products.
    runOp("one x one", 8'd1, 8'd1, 3);
    runOp("five x seven", 8'd5, 8'd7, 1);
    runOp("twelve x twelve", 8'd12, 8'd12, 3);
    runOp("zero x twelve", 8'd0, 8'd12, 0);

    // start and abort together in idle: the start is taken.
    @(negedge clk);
    inA   = 8'd5;
    inB   = 8'd7;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start beats abort busy", busy, 1);
    n = 0;
    while (!done && n < LAT + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("start beats abort latency", n, LAT);
    checkOutput("start beats abort result", result, 1);

    // start held high: back-to-back operations, starts during busy/done are not queued.
    @(negedge clk);
    inA   = 8'd5;
    inB   = 8'd7;
    start = 1'b1;
    doneCount = 0;
    resOk = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        doneCount++;
        if (result !== 8'd1) resOk = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("back to back done count", doneCount, 2);
    checkOutput("back to back results", resOk, 1);
    n = 0;
    while (busy && n < 2 * LAT + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("back to back drains", busy, 0);

    // Reset in the middle of the loop clears outputs at once; the next operation is clean.
    applyStimulus(8'd12, 8'd12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset done", done, 0);
    checkOutput("mid reset result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    runOp("after reset", 8'd12, 8'd12, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
